// File: rtl/tdm_arbiter.sv
// Two-domain time-division arbiter: a free-running slot schedule alternates ownership of one
// fixed-latency resource between L and H, independent of any request activity.
module tdm_arbiter #(
  parameter int unsigned DW   = 16,
  parameter int unsigned SLOT = 8,
  parameter int unsigned LAT  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    lo_req_valid,
  input  logic [DW-1:0]           lo_req_data,
  output logic                    lo_req_ready,
  output logic                    lo_resp_valid,
  output logic [DW-1:0]           lo_resp_data,
  input  logic                    hi_req_valid,
  input  logic [DW-1:0]           hi_req_data,
  output logic                    hi_req_ready,
  output logic                    hi_resp_valid,
  output logic [DW-1:0]           hi_resp_data,
  output logic                    res_en,
  output logic [DW-1:0]           res_wdata,
  input  logic [DW-1:0]           res_rdata,
  output logic                    owner,
  output logic [$clog2(SLOT)-1:0] slot_cnt
);

  localparam int unsigned CW = $clog2(SLOT);
  localparam logic [CW-1:0] LAST_CNT = CW'(SLOT - 1);
  localparam logic [CW-1:0] WIN_END  = CW'(SLOT - 1 - LAT);

  logic           in_win;
  logic           lo_acc;
  logic           hi_acc;
  logic [LAT-1:0] tag_v;
  logic [LAT-1:0] tag_d;
  logic           out_lo;
  logic           out_hi;

  // Ready is a pure function of the schedule; the trailing guard band drains the resource.
  always_comb begin
    in_win       = rst_n && (slot_cnt <= WIN_END);
    lo_req_ready = in_win && !owner;
    hi_req_ready = in_win && owner;
    lo_acc       = lo_req_valid && lo_req_ready;
    hi_acc       = hi_req_valid && hi_req_ready;
    res_en       = lo_acc || hi_acc;
    res_wdata    = '0;
    if (lo_acc) begin
      res_wdata = lo_req_data;
    end else if (hi_acc) begin
      res_wdata = hi_req_data;
    end
  end

  // Slot schedule: counter wraps every SLOT cycles and ownership flips on the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      owner    <= 1'b0;
    end else if (slot_cnt == LAST_CNT) begin
      slot_cnt <= '0;
      owner    <= !owner;
    end else begin
      slot_cnt <= slot_cnt + CW'(1);
    end
  end

  // In-flight tags {valid, domain} travel alongside the resource pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      tag_d <= '0;
    end else begin
      tag_v[0] <= res_en;
      tag_d[0] <= hi_acc;
      for (int i = 1; i < int'(LAT); i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_d[i] <= tag_d[i-1];
      end
    end
  end

  assign out_lo = tag_v[LAT-1] && !tag_d[LAT-1];
  assign out_hi = tag_v[LAT-1] && tag_d[LAT-1];

  // Results are steered only into the issuing domain's response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_resp_valid <= 1'b0;
      hi_resp_valid <= 1'b0;
      lo_resp_data  <= '0;
      hi_resp_data  <= '0;
    end else begin
      lo_resp_valid <= out_lo;
      hi_resp_valid <= out_hi;
      if (out_lo) begin
        lo_resp_data <= res_rdata;
      end
      if (out_hi) begin
        hi_resp_data <= res_rdata;
      end
    end
  end

endmodule

// File: tb/tb_tdm_arbiter.sv
// Directed self-checking bench for tdm_arbiter (DW=16, SLOT=8, LAT=2) with a data+1 resource model.
module tb_tdm_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lo_req_valid;
  logic [15:0] lo_req_data;
  logic        lo_req_ready;
  logic        lo_resp_valid;
  logic [15:0] lo_resp_data;
  logic        hi_req_valid;
  logic [15:0] hi_req_data;
  logic        hi_req_ready;
  logic        hi_resp_valid;
  logic [15:0] hi_resp_data;
  logic        res_en;
  logic [15:0] res_wdata;
  logic [15:0] res_rdata;
  logic        owner;
  logic [2:0]  slot_cnt;

  int passes = 0;
  int total  = 0;

  tdm_arbiter #(.DW(16), .SLOT(8), .LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .lo_req_valid(lo_req_valid), .lo_req_data(lo_req_data), .lo_req_ready(lo_req_ready),
    .lo_resp_valid(lo_resp_valid), .lo_resp_data(lo_resp_data),
    .hi_req_valid(hi_req_valid), .hi_req_data(hi_req_data), .hi_req_ready(hi_req_ready),
    .hi_resp_valid(hi_resp_valid), .hi_resp_data(hi_resp_data),
    .res_en(res_en), .res_wdata(res_wdata), .res_rdata(res_rdata),
    .owner(owner), .slot_cnt(slot_cnt)
  );

  always #5 clk = ~clk;

  // Two-stage resource returning data+1
  logic [15:0] p1 = '0;
  logic [15:0] p2 = '0;
  always @(posedge clk) begin
    p1 <= 16'(res_wdata + 16'd1);
    p2 <= p1;
  end
  assign res_rdata = p2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [39:0] pat;
  logic        exp_rv [0:45];
  logic [15:0] exp_val[0:45];
  logic [15:0] exp_rd [0:45];

  initial begin
    int k;
    logic [15:0] held;
    logic rdy;

    // Reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lo_req_valid = 1'($urandom);
      lo_req_data  = 16'($urandom);
      hi_req_valid = 1'($urandom);
      hi_req_data  = 16'($urandom);
      #1;
      check("rst_res_en", 32'(res_en), 32'd0);
      check("rst_lo_ready", 32'(lo_req_ready), 32'd0);
      tick();
    end
    check("rst_slot_cnt", 32'(slot_cnt), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_hi_ready", 32'(hi_req_ready), 32'd0);
    check("rst_res_wdata", 32'(res_wdata), 32'd0);
    check("rst_lo_rv", 32'(lo_resp_valid), 32'd0);
    check("rst_hi_rv", 32'(hi_resp_valid), 32'd0);
    check("rst_lo_rd", 32'(lo_resp_data), 32'd0);
    check("rst_hi_rd", 32'(hi_resp_data), 32'd0);

    // Single L request, then H request raised mid L slot
    lo_req_valid = 1'b0; lo_req_data = '0; hi_req_valid = 1'b0; hi_req_data = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      lo_req_valid = (c == 0);
      lo_req_data  = (c == 0) ? 16'h0005 : 16'h0000;
      hi_req_valid = (c >= 2 && c <= 8);
      hi_req_data  = 16'h0100;
      #1;
      check("sched_slot_cnt", 32'(slot_cnt), 32'(c % 8));
      check("sched_owner", 32'(owner), 32'(c / 8));
      if (c == 0) begin
        check("l_first_ready", 32'(lo_req_ready), 32'd1);
        check("l_res_en", 32'(res_en), 32'd1);
        check("l_res_wdata", 32'(res_wdata), 32'h0005);
      end
      if (c >= 2 && c <= 7) check("h_wait_ready", 32'(hi_req_ready), 32'd0);
      if (c == 3) begin
        check("l_resp_valid", 32'(lo_resp_valid), 32'd1);
        check("l_resp_data", 32'(lo_resp_data), 32'h0006);
        check("l_hi_rv_quiet", 32'(hi_resp_valid), 32'd0);
      end
      if (c == 4) check("l_resp_pulse", 32'(lo_resp_valid), 32'd0);
      if (c == 6 || c == 7) check("guard_res_en", 32'(res_en), 32'd0);
      if (c == 8) begin
        check("h_ready", 32'(hi_req_ready), 32'd1);
        check("h_lo_ready_off", 32'(lo_req_ready), 32'd0);
        check("h_res_en", 32'(res_en), 32'd1);
        check("h_res_wdata", 32'(res_wdata), 32'h0100);
      end
      if (c == 11) begin
        check("h_resp_valid", 32'(hi_resp_valid), 32'd1);
        check("h_resp_data", 32'(hi_resp_data), 32'h0101);
        check("h_lo_rv_quiet", 32'(lo_resp_valid), 32'd0);
        check("h_lo_rd_hold", 32'(lo_resp_data), 32'h0006);
      end
      if (c == 12) check("h_resp_pulse", 32'(hi_resp_valid), 32'd0);
      tick();
    end

    // Continuous L valid across an L slot and the following H slot
    k = 0;
    hi_req_valid = 1'b0;
    for (int c = 16; c < 32; c++) begin
      lo_req_valid = 1'b1;
      lo_req_data  = 16'(16'h0020 + k);
      #1;
      rdy = (c <= 21);
      check("cont_ready", 32'(lo_req_ready), 32'(rdy));
      check("cont_res_en", 32'(res_en), 32'(rdy));
      check("cont_rv", 32'(lo_resp_valid), 32'(c >= 19 && c <= 24));
      if (c >= 19)
        check("cont_rd", 32'(lo_resp_data), (c <= 24) ? 32'(16'h0021 + (c - 19)) : 32'h0026);
      else
        check("cont_rd_hold", 32'(lo_resp_data), 32'h0006);
      if (rdy) k++;
      tick();
    end

    // Reset one cycle after an accept discards the in-flight tag
    lo_req_valid = 1'b1; lo_req_data = 16'h0040;
    #1;
    check("mid_accept", 32'(res_en), 32'd1);
    tick();
    lo_req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_slot", 32'(slot_cnt), 32'd0);
    check("mid_rst_res_en", 32'(res_en), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("mid_no_lo_rv", 32'(lo_resp_valid), 32'd0);
      check("mid_slot_cnt", 32'(slot_cnt), 32'(i % 8));
      check("mid_owner", 32'(owner), 32'(i / 8));
      tick();
    end
    check("mid_lo_rd_cleared", 32'(lo_resp_data), 32'd0);

    // Noninterference: same L stimulus with H idle, then H saturated
    pat = 40'hA53CF0965B;
    for (int i = 0; i < 46; i++) begin
      exp_rv[i] = 1'b0;
      exp_val[i] = '0;
    end
    for (int i = 0; i < 40; i++) begin
      if (pat[i] && ((i / 8) % 2 == 0) && (i % 8 <= 5)) begin
        exp_rv[i+3]  = 1'b1;
        exp_val[i+3] = 16'(16'h0300 + i + 1);
      end
    end
    held = '0;
    for (int i = 0; i < 46; i++) begin
      if (exp_rv[i]) held = exp_val[i];
      exp_rd[i] = held;
    end
    for (int p = 0; p < 2; p++) begin
      lo_req_valid = 1'b0; hi_req_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 43; i++) begin
        lo_req_valid = (i < 40) ? pat[i] : 1'b0;
        lo_req_data  = 16'(16'h0300 + i);
        hi_req_valid = (p == 1);
        hi_req_data  = 16'(16'hA000 + i);
        #1;
        check(p == 0 ? "ni_idle_ready" : "ni_sat_ready", 32'(lo_req_ready),
              32'(((i / 8) % 2 == 0) && (i % 8 <= 5)));
        check(p == 0 ? "ni_idle_rv" : "ni_sat_rv", 32'(lo_resp_valid), 32'(exp_rv[i]));
        check(p == 0 ? "ni_idle_rd" : "ni_sat_rd", 32'(lo_resp_data), 32'(exp_rd[i]));
        tick();
      end
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/tdm_arbiter.md
# tdm_arbiter

Two-domain time-division arbiter that shares one fixed-latency, single-issue resource between a low-security (L) requester and a high-security (H) requester. Ownership alternates on a fixed, request-independent slot schedule, so L-side timing never depends on H-side activity. Sits between two requester datapaths and one shared datapath instance, as the sequencing layer for alternating-select designs.

## Interface
- DW, 16, request/response data width
- SLOT, 8, cycles per ownership slot (must exceed LAT)
- LAT, 2, resource latency: res_rdata valid LAT cycles after the res_en cycle
- clk  in  1  clock, label L
- rst_n  in  1  asynchronous, active-low reset, label L
- lo_req_valid  in  1  L request valid, label L
- lo_req_data  in  DW  L request payload, label L
- lo_req_ready  out  1  L request accepted this cycle if valid, label L
- lo_resp_valid  out  1  L response valid, label L
- lo_resp_data  out  DW  L response payload, label L
- hi_req_valid  in  1  H request valid, label H
- hi_req_data  in  DW  H request payload, label H
- hi_req_ready  out  1  H request ready, label L (schedule-derived only)
- hi_resp_valid  out  1  H response valid, label H
- hi_resp_data  out  DW  H response payload, label H
- res_en  out  1  issue to resource, label follows owner
- res_wdata  out  DW  issued payload, label follows owner
- res_rdata  in  DW  resource result, label follows tag
- owner  out  1  0 = L slot, 1 = H slot, label L
- slot_cnt  out  $clog2(SLOT)  position in current slot, label L

## Operation
- Free-running slot_cnt counts 0..SLOT-1 every cycle, wraps to 0; owner toggles on wrap. Neither depends on any request input.
- Issue window: cycles with slot_cnt <= SLOT-1-LAT. Outside the window no domain is ready (guard band drains the resource before the slot switch).
- lo_req_ready = (owner==0) && in-window; hi_req_ready = (owner==1) && in-window. Non-owner ready is always 0.
- Accept = valid && ready; res_en = accept (combinational), res_wdata = accepted domain's req_data, else res_wdata = 0.
- One issue per cycle; fully pipelined. A LAT-deep shift register carries {valid, domain} tags.
- When the tag reaching depth LAT is valid, res_rdata is registered into that domain's resp_data and its resp_valid is pulsed for one cycle. The other domain's resp_valid is 0 and its resp_data holds its previous value (never loaded from the other domain).
- Unaccepted requests persist; requester holds valid/data until ready.

## Timing
- Reset (async assert, sync-to-clk deassert handled upstream): slot_cnt=0, owner=0, tags cleared, all ready/valid/res_en = 0, resp_data = 0, res_wdata = 0.
- First cycle after reset release: slot_cnt=0, owner=0, lo_req_ready=1.
- Latency: accept at cycle t -> res_en at t -> res_rdata sampled at t+LAT -> resp_valid high at t+LAT+1.
- Last issue in a slot at slot_cnt=SLOT-1-LAT; its result is sampled at slot_cnt=SLOT-1, response appears at slot_cnt=0 of the next slot (still routed to issuing domain via tag).
- Reset mid-operation: in-flight tags discarded; no response emitted for them.
- Simultaneous L and H valid: only owner is served; no priority logic exists.
- Slot boundary: ready drops for LAT cycles before every owner change.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs 0; release -> slot_cnt 0,1,2..., owner flips after 8 cycles.
- Single L request at slot_cnt=0 with data 0x0005, resource model returns data+1 -> res_en at cycle 0, lo_resp_valid at cycle 3 with 0x0006; hi_resp_valid stays 0.
- H request raised at slot_cnt=2 of an L slot -> hi_req_ready 0 until owner=1, slot_cnt=0 (cycle 8); accepted there, hi_resp_valid at cycle 11.
- Continuous L valid (SLOT=8, LAT=2) -> accepts at slot_cnt 0..5, ready low at 6,7, none during H slot; six responses in order, last at next slot_cnt=0.
- Assert rst_n low one cycle after an accept -> no resp_valid ever emitted for it; schedule restarts at slot_cnt 0, owner 0.
- Noninterference: run identical L stimulus twice with H idle vs H saturated -> lo_req_ready, lo_resp_valid, lo_resp_data traces bit-identical.
